// File: rtl/mdu_hilo_ctrl_if.sv
// E/D-stage multiply/divide interface: MD write requests, HI/LO read-back and stall request.
interface mdu_hilo_ctrl_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        mdUseD;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stallD;

   modport master (
      output start, op, srcA, srcB, mdUseD,
      input  hi, lo, busy, stallD
   );

   modport slave (
      input  start, op, srcA, srcB, mdUseD,
      output hi, lo, busy, stallD
   );
endinterface

// File: rtl/mdu_hilo_ctrl.sv
// Multiply/divide sequencer owning HI/LO; mult/div results land MULT_CYCLES/DIV_CYCLES edges after start.
// New MD-class instructions in D are held by stallD while an operation starts or is in flight.
module mdu_hilo_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic           clk,
   input  logic           rst,
   mdu_hilo_ctrl_if.slave md
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic {IDLE, RUN} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic [1:0]    op_q, op_d;

   logic          is_md_op;
   logic [63:0]   prod_s, prod_u;
   logic          div_signed, a_neg, b_neg;
   logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

   assign is_md_op = ~md.op[2];

   // Results are formed only from the latched operands, so E-stage changes during RUN are invisible.
   assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // Divide on magnitudes so the most-negative / -1 case wraps to 0x80000000 rather than overflowing.
   assign div_signed = ~op_q[0];
   assign a_neg      = div_signed & a_q[31];
   assign b_neg      = div_signed & b_q[31];
   assign a_mag      = a_neg ? (32'd0 - a_q) : a_q;
   assign b_mag      = b_neg ? (32'd0 - b_q) : b_q;
   assign b_safe     = (b_q == 32'd0) ? 32'd1 : b_mag;
   assign q_mag      = a_mag / b_safe;
   assign r_mag      = a_mag % b_safe;
   assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
   assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      case (state_q)
         IDLE: begin
            if (md.start && is_md_op) begin
               a_d     = md.srcA;
               b_d     = md.srcB;
               op_d    = md.op[1:0];
               cnt_d   = md.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
               state_d = RUN;
            end else if (md.start && md.op == 3'd4) begin
               hi_d = md.srcA;
            end else if (md.start && md.op == 3'd5) begin
               lo_d = md.srcA;
            end
         end
         RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               if (!op_q[1]) begin
                  {hi_d, lo_d} = op_q[0] ? prod_u : prod_s;
               end else if (b_q != 32'd0) begin
                  hi_d = rem;
                  lo_d = quot;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
      end
   end

   assign md.hi     = hi_q;
   assign md.lo     = lo_q;
   assign md.busy   = (cnt_q != '0);
   assign md.stallD = md.mdUseD & (md.busy | (md.start & is_md_op));

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Randomized and directed bench for mdu_hilo_ctrl against an arithmetic reference model.
module tb_mdu_hilo_ctrl;
   localparam int unsigned MULT_N = 5;
   localparam int unsigned DIV_N  = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mdu_hilo_ctrl_if md ();

   mdu_hilo_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk (clk),
      .rst (rst),
      .md  (md.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: architectural HI/LO plus one pending result with its due edge.
   logic [31:0] m_hi, m_lo;
   logic [31:0] p_hi, p_lo;
   bit          p_wr;
   bit          m_pending;
   int          m_finish;
   int          edge_cnt = 0;

   always @(posedge clk)
      if (!rst && md.start && md.busy)
         $error("start issued while an MD operation is in flight");

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_cnt);
      end
   endtask

   function automatic void model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rhi, output logic [31:0] rlo, output bit wr);
      longint      sa, sb, sq, sr;
      logic [63:0] p;
      rhi = '0; rlo = '0; wr = 1'b1;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         3'd0: begin p = 64'(sa * sb); {rhi, rlo} = p; end
         3'd1: begin p = {32'd0, a} * {32'd0, b}; {rhi, rlo} = p; end
         3'd2: begin
            if (b == 0) wr = 1'b0;
            else begin sq = sa / sb; sr = sa % sb; rlo = sq[31:0]; rhi = sr[31:0]; end
         end
         default: begin
            if (b == 0) wr = 1'b0;
            else begin rlo = a / b; rhi = a % b; end
         end
      endcase
   endfunction

   task automatic post_checks();
      chk("busy", md.busy, m_pending);
      chk("hi", md.hi, m_hi);
      chk("lo", md.lo, m_lo);
   endtask

   task automatic cycle(input logic st, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic use_d);
      bit set_hi, set_lo;
      set_hi = 0; set_lo = 0;
      md.start = st; md.op = o; md.srcA = a; md.srcB = b; md.mdUseD = use_d;
      #1;
      chk("stallD", md.stallD, use_d & (m_pending | (st & (o <= 3'd3))));
      if (st && !m_pending) begin
         if (o <= 3'd3) begin
            model_op(o, a, b, p_hi, p_lo, p_wr);
            m_pending = 1;
            m_finish  = edge_cnt + 1 + ((o <= 3'd1) ? MULT_N : DIV_N);
         end else if (o == 3'd4) set_hi = 1;
         else if (o == 3'd5) set_lo = 1;
      end
      @(posedge clk); #1;
      edge_cnt++;
      if (set_hi) m_hi = a;
      if (set_lo) m_lo = a;
      if (m_pending && edge_cnt == m_finish) begin
         if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
         m_pending = 0;
      end
      post_checks();
   endtask

   task automatic reset_cycle();
      rst = 1'b1;
      md.start = 1'b0; md.op = 3'd7; md.srcA = $urandom; md.srcB = $urandom; md.mdUseD = 1'b0;
      @(posedge clk); #1;
      edge_cnt++;
      rst = 1'b0;
      m_hi = '0; m_lo = '0; m_pending = 0;
      post_checks();
   endtask

   task automatic idle_cycles(input int n, input logic use_d);
      for (int i = 0; i < n; i++) cycle(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, use_d);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      md.start = 1'b0; md.op = 3'd0; md.srcA = '0; md.srcB = '0; md.mdUseD = 1'b0;
      m_hi = '0; m_lo = '0; m_pending = 0; m_finish = 0; p_wr = 0; p_hi = '0; p_lo = '0;
      @(posedge clk);
      reset_cycle();

      // signed mult with stall held across start and busy window
      cycle(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
      idle_cycles(MULT_N, 1'b1);
      chk("mult_hi", md.hi, 32'hFFFF_FFFF);
      chk("mult_lo", md.lo, 32'hFFFF_FFFA);
      cycle(1'b0, 3'd7, '0, '0, 1'b1);

      // multu; operands change freely during RUN
      cycle(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      idle_cycles(MULT_N, 1'b0);
      chk("multu_hi", md.hi, 32'h0000_0001);
      chk("multu_lo", md.lo, 32'hFFFF_FFFE);

      cycle(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
      idle_cycles(DIV_N, 1'b1);
      chk("div_lo", md.lo, 32'hFFFF_FFFD);
      chk("div_hi", md.hi, 32'hFFFF_FFFF);

      cycle(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      idle_cycles(DIV_N, 1'b0);
      chk("divu_lo", md.lo, 32'h7FFF_FFFC);
      chk("divu_hi", md.hi, 32'h0000_0001);

      cycle(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      idle_cycles(DIV_N, 1'b0);
      chk("div_ovf_lo", md.lo, 32'h8000_0000);
      chk("div_ovf_hi", md.hi, 32'h0000_0000);

      cycle(1'b1, 3'd4, 32'h0000_1234, $urandom, 1'b1);
      cycle(1'b1, 3'd5, 32'h0000_5678, $urandom, 1'b1);
      chk("mthi", md.hi, 32'h0000_1234);
      chk("mtlo", md.lo, 32'h0000_5678);

      // divide by zero keeps HI/LO
      cycle(1'b1, 3'd4, 32'h0000_000A, '0, 1'b0);
      cycle(1'b1, 3'd5, 32'h0000_000B, '0, 1'b0);
      cycle(1'b1, 3'd2, 32'h0000_0064, 32'd0, 1'b1);
      idle_cycles(DIV_N, 1'b1);
      chk("div0_hi", md.hi, 32'h0000_000A);
      chk("div0_lo", md.lo, 32'h0000_000B);

      // reset in the third busy cycle aborts the divide
      cycle(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
      idle_cycles(2, 1'b0);
      reset_cycle();
      chk("rst_busy", md.busy, 1'b0);
      chk("rst_hi", md.hi, 32'd0);
      cycle(1'b0, 3'd7, '0, '0, 1'b1);

      for (int i = 0; i < 600; i++) begin
         logic st;
         st = m_pending ? 1'b0 : ($urandom_range(0, 2) != 0);
         cycle(st, 3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
      end
      idle_cycles(DIV_N + 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
